// File: rtl/fifo_param_if.sv
// fifo_param_if - producer/consumer bundle for fifo_param.
//   master : drives Data_In, FInN, FOutN, FClrN, AF_Thr, AE_Thr; observes status/data
//   slave  : the FIFO itself; the mirror image of master
//   Widths follow FWIDTH (data) and FCWIDTH (pointer; level is FCWIDTH+1 bits).
interface fifo_param_if #(
  parameter int FWIDTH  = 32,
  parameter int FCWIDTH = 4
);
  logic [FWIDTH-1:0]  Data_In;
  logic               FInN;
  logic               FOutN;
  logic               FClrN;
  logic [FCWIDTH:0]   AF_Thr;
  logic [FCWIDTH:0]   AE_Thr;
  logic [FWIDTH-1:0]  F_Data;
  logic               F_DValid;
  logic [FCWIDTH:0]   F_Level;
  logic               F_FullN;
  logic               F_EmptyN;
  logic               F_AFullN;
  logic               F_AEmptyN;
  logic               F_OvfN;
  logic               F_UdfN;

  modport master (
    output Data_In, FInN, FOutN, FClrN, AF_Thr, AE_Thr,
    input  F_Data, F_DValid, F_Level, F_FullN, F_EmptyN,
           F_AFullN, F_AEmptyN, F_OvfN, F_UdfN
  );

  modport slave (
    input  Data_In, FInN, FOutN, FClrN, AF_Thr, AE_Thr,
    output F_Data, F_DValid, F_Level, F_FullN, F_EmptyN,
           F_AFullN, F_AEmptyN, F_OvfN, F_UdfN
  );
endinterface

// File: rtl/fifo_param.sv
// fifo_param - parametrised single-clock FIFO.
//   Clk  : rising-edge clock
//   Rst  : asynchronous active-high reset
//   bus  : fifo_param_if.slave
//          inputs  Data_In, FInN (write, low), FOutN (read, low), FClrN (sync clear, low),
//                  AF_Thr / AE_Thr (run-time almost-full / almost-empty thresholds)
//          outputs F_Data, F_DValid, F_Level, F_FullN, F_EmptyN, F_AFullN, F_AEmptyN,
//                  sticky F_OvfN / F_UdfN
//   SHOWAHEAD=0 : registered read, data and F_DValid one cycle after the strobe.
//   SHOWAHEAD=1 : head word presented combinationally, strobe pops it.
module fifo_param #(
  parameter int FWIDTH    = 32,
  parameter int FDEPTH    = 16,
  parameter int FCWIDTH   = 4,
  parameter int SHOWAHEAD = 0
) (
  input logic        Clk,
  input logic        Rst,
  fifo_param_if.slave bus
);

  localparam logic [FCWIDTH:0]   DEPTH_L = (FCWIDTH+1)'(FDEPTH);
  localparam logic [FCWIDTH:0]   LVL_ONE = (FCWIDTH+1)'(1);
  localparam logic [FCWIDTH-1:0] PTR_ONE = FCWIDTH'(1);

  logic [FWIDTH-1:0]  mem [FDEPTH];
  logic [FCWIDTH-1:0] wrPtr;
  logic [FCWIDTH-1:0] rdPtr;
  logic [FCWIDTH:0]   level;
  logic [FCWIDTH:0]   levelNxt;
  logic               clrReq;
  logic               rdOk;
  logic               wrOk;
  logic               ovfEv;
  logic               udfEv;
  logic               fullN;
  logic               emptyN;
  logic               aFullN;
  logic               aEmptyN;
  logic               ovfN;
  logic               udfN;

  // A clear swallows both strobes, so neither acceptance nor error events
  // are produced in that cycle. A full FIFO still takes a write when a read
  // frees the slot in the same cycle.
  always_comb begin
    clrReq   = !bus.FClrN;
    rdOk     = !bus.FOutN && (level != '0) && !clrReq;
    wrOk     = !bus.FInN && ((level != DEPTH_L) || rdOk) && !clrReq;
    ovfEv    = !bus.FInN && !wrOk && !clrReq;
    udfEv    = !bus.FOutN && (level == '0) && !clrReq;
    levelNxt = level;
    if (clrReq) begin
      levelNxt = '0;
    end else if (wrOk && !rdOk) begin
      levelNxt = level + LVL_ONE;
    end else if (rdOk && !wrOk) begin
      levelNxt = level - LVL_ONE;
    end
  end

  // Control state: pointers, level, and status decoded from the next level
  // so flags always agree with F_Level after the same edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      level   <= '0;
      emptyN  <= 1'b0;
      fullN   <= 1'b1;
      aFullN  <= 1'b1;
      aEmptyN <= 1'b0;
      ovfN    <= 1'b1;
      udfN    <= 1'b1;
    end else begin
      if (clrReq) begin
        wrPtr <= '0;
        rdPtr <= '0;
        ovfN  <= 1'b1;
        udfN  <= 1'b1;
      end else begin
        if (wrOk) wrPtr <= wrPtr + PTR_ONE;
        if (rdOk) rdPtr <= rdPtr + PTR_ONE;
        ovfN <= ovfN & ~ovfEv;
        udfN <= udfN & ~udfEv;
      end
      level   <= levelNxt;
      emptyN  <= (levelNxt != '0);
      fullN   <= (levelNxt != DEPTH_L);
      aFullN  <= !(levelNxt >= bus.AF_Thr);
      aEmptyN <= !(levelNxt <= bus.AE_Thr);
    end
  end

  // Storage array: no reset, contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (wrOk) mem[wrPtr] <= bus.Data_In;
  end

  generate
    if (SHOWAHEAD == 0) begin : gRegRead
      logic [FWIDTH-1:0] fData_p1;
      logic              vld_p1;

      // Read stage: word at rdPtr captured on an accepted read.
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          fData_p1 <= '0;
          vld_p1   <= 1'b0;
        end else begin
          vld_p1 <= rdOk;
          if (rdOk) fData_p1 <= mem[rdPtr];
        end
      end

      assign bus.F_Data   = fData_p1;
      assign bus.F_DValid = vld_p1;
    end else begin : gShowAhead
      // Zeros when empty so stale memory never leaks onto the bus.
      assign bus.F_Data   = emptyN ? mem[rdPtr] : '0;
      assign bus.F_DValid = 1'b0;
    end
  endgenerate

  assign bus.F_Level   = level;
  assign bus.F_FullN   = fullN;
  assign bus.F_EmptyN  = emptyN;
  assign bus.F_AFullN  = aFullN;
  assign bus.F_AEmptyN = aEmptyN;
  assign bus.F_OvfN    = ovfN;
  assign bus.F_UdfN    = udfN;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param - directed bench for fifo_param (FWIDTH=8, FDEPTH=4).
//   u0 : SHOWAHEAD=0 instance on bus0, u1 : SHOWAHEAD=1 instance on bus1.
module tb_fifo_param;
  logic Clk;
  logic Rst;
  int   passCnt;
  int   totalCnt;

  fifo_param_if #(.FWIDTH(8), .FCWIDTH(2)) bus0 ();
  fifo_param_if #(.FWIDTH(8), .FCWIDTH(2)) bus1 ();

  fifo_param #(.FWIDTH(8), .FDEPTH(4), .FCWIDTH(2), .SHOWAHEAD(0)) u0 (
    .Clk(Clk), .Rst(Rst), .bus(bus0));
  fifo_param #(.FWIDTH(8), .FDEPTH(4), .FCWIDTH(2), .SHOWAHEAD(1)) u1 (
    .Clk(Clk), .Rst(Rst), .bus(bus1));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive0(input logic inN, input logic outN, input logic clrN, input logic [7:0] d);
    bus0.FInN = inN; bus0.FOutN = outN; bus0.FClrN = clrN; bus0.Data_In = d;
  endtask

  task automatic drive1(input logic inN, input logic outN, input logic [7:0] d);
    bus1.FInN = inN; bus1.FOutN = outN; bus1.FClrN = 1'b1; bus1.Data_In = d;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    drive0(1'b1, 1'b1, 1'b1, 8'h00);
    drive1(1'b1, 1'b1, 8'h00);
    bus0.AF_Thr = 3'd3; bus0.AE_Thr = 3'd1;
    bus1.AF_Thr = 3'd3; bus1.AE_Thr = 3'd1;
    tick(); tick();
    totalCnt++; if (bus0.F_Data !== 8'h00) $display("FAIL rst_data got %h want 00", bus0.F_Data); else passCnt++;
    totalCnt++; if (bus0.F_DValid !== 1'b0) $display("FAIL rst_dvalid got %b want 0", bus0.F_DValid); else passCnt++;
    totalCnt++; if (bus0.F_Level !== 3'd0) $display("FAIL rst_level got %0d want 0", bus0.F_Level); else passCnt++;
    totalCnt++; if ({bus0.F_EmptyN, bus0.F_FullN, bus0.F_AFullN, bus0.F_AEmptyN} !== 4'b0110)
      $display("FAIL rst_status got %b want 0110", {bus0.F_EmptyN, bus0.F_FullN, bus0.F_AFullN, bus0.F_AEmptyN}); else passCnt++;
    totalCnt++; if ({bus0.F_OvfN, bus0.F_UdfN} !== 2'b11) $display("FAIL rst_sticky got %b want 11", {bus0.F_OvfN, bus0.F_UdfN}); else passCnt++;
    totalCnt++; if (bus1.F_Data !== 8'h00) $display("FAIL rst_sa_data got %h want 00", bus1.F_Data); else passCnt++;
    @(negedge Clk);
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_overflow_read();
    logic [7:0] wd [4];
    logic [3:0] expAF;
    logic [3:0] expAE;
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
    // AF_Thr=3: low at levels 3,4. AE_Thr=1: low at level 1 (index = level-1).
    expAF = 4'b0011; expAE = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b0, 1'b1, 1'b1, wd[i]);
      tick();
      totalCnt++; if (bus0.F_Level !== 3'(i + 1)) $display("FAIL fill_level%0d got %0d want %0d", i, bus0.F_Level, i + 1); else passCnt++;
      totalCnt++; if (bus0.F_AFullN !== expAF[i]) $display("FAIL fill_afull%0d got %b want %b", i, bus0.F_AFullN, expAF[i]); else passCnt++;
      totalCnt++; if (bus0.F_AEmptyN !== expAE[i]) $display("FAIL fill_aempty%0d got %b want %b", i, bus0.F_AEmptyN, expAE[i]); else passCnt++;
    end
    totalCnt++; if (bus0.F_FullN !== 1'b0) $display("FAIL full_flag got %b want 0", bus0.F_FullN); else passCnt++;
    drive0(1'b0, 1'b1, 1'b1, 8'h55);
    tick();
    totalCnt++; if (bus0.F_OvfN !== 1'b0) $display("FAIL ovf_flag got %b want 0", bus0.F_OvfN); else passCnt++;
    totalCnt++; if (bus0.F_Level !== 3'd4) $display("FAIL ovf_level got %0d want 4", bus0.F_Level); else passCnt++;
    drive0(1'b1, 1'b1, 1'b1, 8'h00);
    tick();
    totalCnt++; if (bus0.F_OvfN !== 1'b0) $display("FAIL ovf_sticky got %b want 0", bus0.F_OvfN); else passCnt++;
    totalCnt++; if (bus0.F_DValid !== 1'b0) $display("FAIL idle_dvalid got %b want 0", bus0.F_DValid); else passCnt++;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b0, 1'b1, 8'h00);
      tick();
      totalCnt++; if (bus0.F_Data !== wd[i]) $display("FAIL rd_data%0d got %h want %h", i, bus0.F_Data, wd[i]); else passCnt++;
      totalCnt++; if (bus0.F_DValid !== 1'b1) $display("FAIL rd_dvalid%0d got %b want 1", i, bus0.F_DValid); else passCnt++;
    end
    drive0(1'b1, 1'b1, 1'b1, 8'h00);
    tick();
    totalCnt++; if (bus0.F_DValid !== 1'b0) $display("FAIL rd_done_dvalid got %b want 0", bus0.F_DValid); else passCnt++;
    totalCnt++; if (bus0.F_Data !== 8'h44) $display("FAIL rd_hold got %h want 44", bus0.F_Data); else passCnt++;
    totalCnt++; if ({bus0.F_Level, bus0.F_EmptyN} !== 4'b0000) $display("FAIL rd_empty got %b want 0000", {bus0.F_Level, bus0.F_EmptyN}); else passCnt++;
  endtask

  task automatic test_simul_empty();
    drive0(1'b0, 1'b0, 1'b1, 8'hA5);
    tick();
    totalCnt++; if (bus0.F_Level !== 3'd1) $display("FAIL se_level got %0d want 1", bus0.F_Level); else passCnt++;
    totalCnt++; if (bus0.F_UdfN !== 1'b0) $display("FAIL se_udf got %b want 0", bus0.F_UdfN); else passCnt++;
    totalCnt++; if (bus0.F_DValid !== 1'b0) $display("FAIL se_dvalid got %b want 0", bus0.F_DValid); else passCnt++;
    drive0(1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    totalCnt++; if (bus0.F_Data !== 8'hA5) $display("FAIL se_read got %h want a5", bus0.F_Data); else passCnt++;
    totalCnt++; if (bus0.F_Level !== 3'd0) $display("FAIL se_level0 got %0d want 0", bus0.F_Level); else passCnt++;
  endtask

  task automatic test_clear();
    drive0(1'b0, 1'b1, 1'b1, 8'h66); tick();
    drive0(1'b0, 1'b1, 1'b1, 8'h77); tick();
    drive0(1'b0, 1'b0, 1'b0, 8'h99);
    tick();
    totalCnt++; if (bus0.F_Level !== 3'd0) $display("FAIL clr_level got %0d want 0", bus0.F_Level); else passCnt++;
    totalCnt++; if ({bus0.F_EmptyN, bus0.F_FullN, bus0.F_AFullN, bus0.F_AEmptyN} !== 4'b0110)
      $display("FAIL clr_status got %b want 0110", {bus0.F_EmptyN, bus0.F_FullN, bus0.F_AFullN, bus0.F_AEmptyN}); else passCnt++;
    totalCnt++; if ({bus0.F_OvfN, bus0.F_UdfN} !== 2'b11) $display("FAIL clr_sticky got %b want 11", {bus0.F_OvfN, bus0.F_UdfN}); else passCnt++;
    totalCnt++; if (bus0.F_DValid !== 1'b0) $display("FAIL clr_dvalid got %b want 0", bus0.F_DValid); else passCnt++;
    totalCnt++; if (bus0.F_Data !== 8'hA5) $display("FAIL clr_hold got %h want a5", bus0.F_Data); else passCnt++;
    drive0(1'b1, 1'b1, 1'b1, 8'h00);
    tick();
    totalCnt++; if (bus0.F_Level !== 3'd0) $display("FAIL clr_ignored got %0d want 0", bus0.F_Level); else passCnt++;
    drive0(1'b0, 1'b1, 1'b1, 8'hC3); tick();
    drive0(1'b1, 1'b0, 1'b1, 8'h00); tick();
    totalCnt++; if (bus0.F_Data !== 8'hC3) $display("FAIL clr_after got %h want c3", bus0.F_Data); else passCnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive0(1'b0, 1'b1, 1'b1, 8'(i + 1));
      tick();
    end
    totalCnt++; if (bus0.F_Level !== 3'd4) $display("FAIL b2b_fill got %0d want 4", bus0.F_Level); else passCnt++;
    for (int i = 0; i < 8; i++) begin
      drive0(1'b0, 1'b0, 1'b1, 8'(i + 5));
      tick();
      totalCnt++; if (bus0.F_Data !== 8'(i + 1)) $display("FAIL b2b_data%0d got %h want %h", i, bus0.F_Data, 8'(i + 1)); else passCnt++;
      totalCnt++; if (bus0.F_Level !== 3'd4) $display("FAIL b2b_level%0d got %0d want 4", i, bus0.F_Level); else passCnt++;
    end
    totalCnt++; if (bus0.F_OvfN !== 1'b1) $display("FAIL b2b_ovf got %b want 1", bus0.F_OvfN); else passCnt++;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b0, 1'b1, 8'h00);
      tick();
      totalCnt++; if (bus0.F_Data !== 8'(i + 9)) $display("FAIL b2b_drain%0d got %h want %h", i, bus0.F_Data, 8'(i + 9)); else passCnt++;
    end
    drive0(1'b1, 1'b1, 1'b1, 8'h00);
    tick();
  endtask

  task automatic test_thresholds();
    drive0(1'b0, 1'b1, 1'b1, 8'hE1); tick();
    drive0(1'b0, 1'b1, 1'b1, 8'hE2); tick();
    drive0(1'b1, 1'b1, 1'b1, 8'h00);
    totalCnt++; if ({bus0.F_AFullN, bus0.F_AEmptyN} !== 2'b11) $display("FAIL thr_lvl2 got %b want 11", {bus0.F_AFullN, bus0.F_AEmptyN}); else passCnt++;
    bus0.AF_Thr = 3'd2;
    tick();
    totalCnt++; if (bus0.F_AFullN !== 1'b0) $display("FAIL thr_af2 got %b want 0", bus0.F_AFullN); else passCnt++;
    bus0.AE_Thr = 3'd2;
    tick();
    totalCnt++; if (bus0.F_AEmptyN !== 1'b0) $display("FAIL thr_ae2 got %b want 0", bus0.F_AEmptyN); else passCnt++;
    bus0.AF_Thr = 3'd3; bus0.AE_Thr = 3'd1;
    drive0(1'b1, 1'b0, 1'b1, 8'h00); tick(); tick();
    drive0(1'b1, 1'b1, 1'b1, 8'h00); tick();
    totalCnt++; if ({bus0.F_Level, bus0.F_AFullN, bus0.F_AEmptyN} !== 5'b00010) $display("FAIL thr_drain got %b want 00010", {bus0.F_Level, bus0.F_AFullN, bus0.F_AEmptyN}); else passCnt++;
  endtask

  task automatic test_showahead();
    drive1(1'b0, 1'b1, 8'h5A);
    tick();
    drive1(1'b1, 1'b1, 8'h00);
    totalCnt++; if (bus1.F_Data !== 8'h5A) $display("FAIL sa_data got %h want 5a", bus1.F_Data); else passCnt++;
    totalCnt++; if (bus1.F_EmptyN !== 1'b1) $display("FAIL sa_emptyn got %b want 1", bus1.F_EmptyN); else passCnt++;
    drive1(1'b1, 1'b0, 8'h00);
    tick();
    drive1(1'b1, 1'b1, 8'h00);
    totalCnt++; if (bus1.F_Data !== 8'h00) $display("FAIL sa_pop got %h want 00", bus1.F_Data); else passCnt++;
    totalCnt++; if ({bus1.F_EmptyN, bus1.F_DValid} !== 2'b00) $display("FAIL sa_empty got %b want 00", {bus1.F_EmptyN, bus1.F_DValid}); else passCnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      drive0(1'b0, 1'b1, 1'b1, 8'(8'hD1 + i));
      tick();
    end
    drive0(1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    drive0(1'b1, 1'b1, 1'b1, 8'h00);
    totalCnt++; if ({bus0.F_Level, bus0.F_Data} !== {3'd3, 8'hD1}) $display("FAIL ar_pre got %0d/%h want 3/d1", bus0.F_Level, bus0.F_Data); else passCnt++;
    #2;
    Rst = 1'b1;
    #1;
    totalCnt++; if (bus0.F_Level !== 3'd0) $display("FAIL ar_level got %0d want 0", bus0.F_Level); else passCnt++;
    totalCnt++; if ({bus0.F_Data, bus0.F_DValid} !== 9'h000) $display("FAIL ar_data got %h/%b want 00/0", bus0.F_Data, bus0.F_DValid); else passCnt++;
    totalCnt++; if ({bus0.F_EmptyN, bus0.F_FullN, bus0.F_AFullN, bus0.F_AEmptyN, bus0.F_OvfN, bus0.F_UdfN} !== 6'b011011)
      $display("FAIL ar_status got %b want 011011", {bus0.F_EmptyN, bus0.F_FullN, bus0.F_AFullN, bus0.F_AEmptyN, bus0.F_OvfN, bus0.F_UdfN}); else passCnt++;
    @(negedge Clk);
    Rst = 1'b0;
    tick();
    totalCnt++; if (bus0.F_Level !== 3'd0) $display("FAIL ar_after got %0d want 0", bus0.F_Level); else passCnt++;
  endtask

  initial begin
    passCnt  = 0;
    totalCnt = 0;
    test_reset();
    test_fill_overflow_read();
    test_simul_empty();
    test_clear();
    test_back_to_back();
    test_thresholds();
    test_showahead();
    test_async_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the fixed 32x4 FIFO used across the chapter designs. Width and depth are generic, and the almost-full/almost-empty thresholds are programmable at run time. A fill-level output, sticky overflow/underflow flags and a selectable read mode (registered or show-ahead) are added. It sits between a producer and a consumer in one clock domain and replaces the fixed FIFO plus its memory block as a single module.

## Interface
- FWIDTH, 32, data width in bits (>=1)
- FDEPTH, 16, number of words; power of two, >=4
- FCWIDTH, 4, log2(FDEPTH); pointer width
- SHOWAHEAD, 0, 0 = registered read (data one cycle after strobe), 1 = show-ahead (head word always presented)
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  asynchronous, active-high reset
- Data_In  in  FWIDTH  write data
- FInN  in  1  write strobe, active low
- FOutN  in  1  read strobe, active low
- FClrN  in  1  synchronous clear, active low
- AF_Thr  in  FCWIDTH+1  almost-full threshold (level >= AF_Thr)
- AE_Thr  in  FCWIDTH+1  almost-empty threshold (level <= AE_Thr)
- F_Data  out  FWIDTH  read data
- F_DValid  out  1  high one cycle when F_Data carries a newly read word (SHOWAHEAD=0 only; tied 0 otherwise)
- F_Level  out  FCWIDTH+1  words currently stored, 0..FDEPTH
- F_FullN / F_EmptyN  out  1 each  full / empty, active low
- F_AFullN / F_AEmptyN  out  1 each  almost-full / almost-empty, active low
- F_OvfN / F_UdfN  out  1 each  sticky overflow / underflow, active low

## Operation
- Read accepted (rd_ok) = FOutN==0 and level>0.
- Write accepted (wr_ok) = FInN==0 and (level<FDEPTH or rd_ok).
  - A write to a full FIFO therefore succeeds only when a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr] <= Data_In; wr_ptr+1.
- Accepted read: rd_ptr+1.
- Both pointers wrap modulo FDEPTH naturally.
- Level update: next level = level + wr_ok - rd_ok. It never leaves 0..FDEPTH.
- Empty with FInN=0 and FOutN=0 in the same cycle: write is accepted, read is rejected, underflow is flagged, level becomes 1.
- Overflow: FInN=0 and write not accepted. F_OvfN goes to 0 and stays there until clear or reset. The write is dropped and the contents are unchanged.
- Underflow: FOutN=0 and level==0. F_UdfN goes to 0 and stays there. Pointers are unchanged.
- Status flags are registered and decoded from next level, so they are always consistent with F_Level in the same cycle:
  - F_EmptyN = (level!=0)
  - F_FullN = (level!=FDEPTH)
  - F_AFullN = !(level>=AF_Thr)
  - F_AEmptyN = !(level<=AE_Thr)
  - Thresholds are used as presented in the cycle of the update. A threshold change with no read or write takes effect at the next edge; flags are recomputed every cycle.
- Clear (FClrN==0):
  - Pointers and level go to 0, sticky flags are cleared, status returns to reset values.
  - F_DValid goes to 0. In SHOWAHEAD=0, F_Data holds its last value.
  - Any read or write strobe in that cycle is ignored and not flagged.
  - Memory contents are not cleared.
- SHOWAHEAD=0: on rd_ok, F_Data <= mem[rd_ptr] and F_DValid=1 on the following cycle. Otherwise F_Data holds and F_DValid=0.
- SHOWAHEAD=1: F_Data = mem[rd_ptr] when F_EmptyN==1, otherwise all zeros. Asserting FOutN pops the presented word.

## Timing
- Reset values:
  - F_Data=0, F_DValid=0, F_Level=0
  - F_EmptyN=0, F_FullN=1, F_AFullN=1 (for AF_Thr>0), F_AEmptyN=0
  - F_OvfN=1, F_UdfN=1
  - Pointers at 0
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for an edge. Memory contents are undefined afterwards.
- Write-to-visible latency: a word written at edge N raises F_EmptyN and F_Level at edge N. In SHOWAHEAD=1 it appears on F_Data after edge N. In SHOWAHEAD=0 it can be read with a strobe in cycle N+1, and the data appears after edge N+1.
- Read latency (SHOWAHEAD=0): strobe sampled at edge N; F_Data/F_DValid valid from edge N until edge N+1.
- Full throughput: one write and one read per cycle sustained at any level, including full. Level is unchanged when both are accepted.
- Flags and level change only at rising edges, except on async reset.

## Test plan
- FWIDTH=8, FDEPTH=4, SHOWAHEAD=0: write 0x11,0x22,0x33,0x44 on consecutive cycles -> F_Level 1,2,3,4; F_FullN=0 after the 4th edge. A 5th write -> F_OvfN=0, level stays 4. Then read 4 -> F_Data 0x11..0x44, each with F_DValid=1 one cycle after its strobe.
- Empty FIFO, FInN=0 and FOutN=0 together with Data_In=0xA5 -> level=1, F_UdfN=0, F_DValid=0. Next read -> 0xA5.
- Full FIFO (4 words), simultaneous read+write for 8 cycles -> level stays 4, no overflow, data order preserved across pointer wrap.
- AF_Thr=3, AE_Thr=1: fill 0..4 -> F_AEmptyN low at levels 0 and 1, F_AFullN low at levels 3 and 4. Change AF_Thr to 2 at level 2 with idle strobes -> F_AFullN goes low after one edge.
- SHOWAHEAD=1: write 0x5A to empty -> F_Data=0x5A in the cycle after the write. A read strobe in that cycle -> F_Data=0x00 and F_EmptyN=0 after the edge.
- Mid-stream: assert FClrN=0 with a read and write pending -> level 0, flags at reset values, sticky flags cleared, strobes ignored. Assert Rst between edges at level 3 -> outputs reset immediately.
